// File: rtl/can_rx_bit_timing.sv
// CAN receive bit-timing unit: input synchroniser, tq prescaler, bit-segment
// FSM with hard sync / SJW-limited resync, single or 3-point majority
// sampling, and destuffing in front of the frame decoder.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a recessive-to-dominant edge (SOF hard sync)
// SYNC_SEG | one tq; the edge clk is its first clk
// SEG1     | prop+phase1, TSEG1 tq plus any resync extension
// SEG2     | phase2, TSEG2 tq minus any resync shortening
module can_rx_bit_timing #(
  parameter int BRP           = 10,
  parameter int TSEG1         = 6,
  parameter int TSEG2         = 3,
  parameter int SJW           = 1,
  parameter int TRIPLE_SAMPLE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  input  logic destuff_en,
  output logic dout,
  output logic dvalid,
  output logic stuff_err,
  output logic sample_tick
);

  localparam int PW = (BRP > 1) ? $clog2(BRP) : 1;
  localparam int TW = $clog2(TSEG1 + TSEG2 + SJW + 1);
  localparam logic [PW-1:0] PS_LAST = PW'(BRP - 1);
  localparam logic [TW-1:0] T1  = TW'(TSEG1);
  localparam logic [TW-1:0] T2  = TW'(TSEG2);
  localparam logic [TW-1:0] SJ  = TW'(SJW);
  localparam logic [TW-1:0] ONE = TW'(1);

  typedef enum logic [1:0] {IDLE, SYNC_SEG, SEG1, SEG2} state_t;

  state_t        state, cur_state, seg_next;
  logic [PW-1:0] ps, cur_ps;
  logic [TW-1:0] tq_cnt, cur_tq, ext, cur_ext, short_len, cur_short;
  logic [TW-1:0] ext_eff, short_eff, r_left;
  logic          s1, ds, ds_prev, fall;
  logic          restart, resync_ok, rs_seg1, rs_seg2;
  logic          tq_end, seg_last, sample_pt, bit_val, maj;
  logic          resync_done, sampled, samp_prev, last_bit;
  logic [1:0]    tri_sr;
  logic [2:0]    run;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b1;
      ds      <= 1'b1;
      ds_prev <= 1'b1;
    end else begin
      s1      <= din;
      ds      <= s1;
      ds_prev <= ds;
    end
  end

  // Timing view of the current clk; a restart makes this clk count 0 of SYNC_SEG.
  always_comb begin
    fall      = ds_prev & ~ds;
    resync_ok = fall & samp_prev & ~resync_done;
    r_left    = T2 - short_len - tq_cnt;
    restart   = en & fall & ((state == IDLE) |
                ((state == SEG2) & resync_ok & (r_left <= SJ)));
    cur_state = restart ? SYNC_SEG : state;
    cur_ps    = restart ? '0 : ps;
    cur_tq    = restart ? '0 : tq_cnt;
    cur_ext   = restart ? '0 : ext;
    cur_short = restart ? '0 : short_len;
    rs_seg1   = en & resync_ok & (state == SEG1);
    rs_seg2   = en & resync_ok & (state == SEG2) & ~restart;
    ext_eff   = cur_ext;
    if (rs_seg1)
      ext_eff = ((tq_cnt + ONE) < SJ) ? (tq_cnt + ONE) : SJ;
    short_eff = rs_seg2 ? SJ : cur_short;
    tq_end    = (cur_ps == PS_LAST);
    seg_last  = 1'b0;
    seg_next  = IDLE;
    case (cur_state)
      SYNC_SEG: begin seg_last = 1'b1;                              seg_next = SEG1;     end
      SEG1:     begin seg_last = (cur_tq == T1 + ext_eff - ONE);    seg_next = SEG2;     end
      SEG2:     begin seg_last = (cur_tq == T2 - short_eff - ONE);  seg_next = SYNC_SEG; end
      default:  begin seg_last = 1'b0;                              seg_next = IDLE;     end
    endcase
    // Sample point uses the pre-edge SEG1 length so an edge on this clk cannot move it.
    sample_pt = en & (cur_state == SEG1) & tq_end & ~sampled &
                (cur_tq == T1 + cur_ext - ONE);
    maj       = (tri_sr[1] & tri_sr[0]) | (tri_sr[1] & ds) | (tri_sr[0] & ds);
    bit_val   = (TRIPLE_SAMPLE != 0) ? maj : ds;
  end

  // Bit-segment FSM, resync bookkeeping, sampling and destuffing with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ps          <= '0;
      tq_cnt      <= '0;
      ext         <= '0;
      short_len   <= '0;
      resync_done <= 1'b0;
      sampled     <= 1'b0;
      samp_prev   <= 1'b1;
      last_bit    <= 1'b0;
      run         <= '0;
      tri_sr      <= 2'b11;
      dout        <= 1'b1;
      dvalid      <= 1'b0;
      stuff_err   <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      dvalid      <= 1'b0;
      stuff_err   <= 1'b0;
      sample_tick <= 1'b0;
      if (!en) begin
        state       <= IDLE;
        ps          <= '0;
        tq_cnt      <= '0;
        ext         <= '0;
        short_len   <= '0;
        resync_done <= 1'b0;
        sampled     <= 1'b0;
        samp_prev   <= 1'b1;
        last_bit    <= 1'b0;
        run         <= '0;
      end else if (cur_state != IDLE) begin
        ps <= tq_end ? '0 : cur_ps + PW'(1);
        if (tq_end && seg_last) begin
          state  <= seg_next;
          tq_cnt <= '0;
        end else begin
          state  <= cur_state;
          tq_cnt <= tq_end ? cur_tq + ONE : cur_tq;
        end
        if (restart || (tq_end && seg_last && cur_state == SEG2)) begin
          ext         <= '0;
          short_len   <= '0;
          resync_done <= 1'b0;
          sampled     <= 1'b0;
        end else begin
          ext       <= ext_eff;
          short_len <= short_eff;
          if (rs_seg1 || rs_seg2) resync_done <= 1'b1;
          if (sample_pt) sampled <= 1'b1;
        end
        if (tq_end && cur_state == SEG1) tri_sr <= {tri_sr[0], ds};
        if (sample_pt) begin
          sample_tick <= 1'b1;
          samp_prev   <= bit_val;
          if (destuff_en && run == 3'd5) begin
            if (bit_val == last_bit) begin
              stuff_err <= 1'b1;
            end else begin
              run      <= 3'd1;
              last_bit <= bit_val;
            end
          end else begin
            dvalid   <= 1'b1;
            dout     <= bit_val;
            last_bit <= bit_val;
            if (!destuff_en)
              run <= '0;
            else if (run != 3'd0 && bit_val == last_bit)
              run <= run + 3'd1;
            else
              run <= 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_can_rx_bit_timing.sv
// Bench for can_rx_bit_timing: one single-sample and one triple-sample
// instance share the stimulus; expected events are queued per instance as
// each scenario is driven and popped as the instances produce them.
module tb_can_rx_bit_timing;

  logic clk = 1'b0;
  logic rst_n, en, din, destuff_en;
  logic dout_s, dvalid_s, serr_s, tick_s;
  logic dout_t, dvalid_t, serr_t, tick_t;
  logic o_dout[2], o_dv[2], o_se[2], o_tk[2];

  typedef struct { int cyc; logic d; } ev_t;
  ev_t qv[2][$];
  int  qe[2][$];
  int  qt[2][$];
  ev_t m_e;
  int  m_c;
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  t_ref = 0;

  can_rx_bit_timing #(.TRIPLE_SAMPLE(0)) u_single (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .destuff_en(destuff_en),
    .dout(dout_s), .dvalid(dvalid_s), .stuff_err(serr_s), .sample_tick(tick_s));

  can_rx_bit_timing #(.TRIPLE_SAMPLE(1)) u_triple (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .destuff_en(destuff_en),
    .dout(dout_t), .dvalid(dvalid_t), .stuff_err(serr_t), .sample_tick(tick_t));

  always_comb begin
    o_dout[0] = dout_s;  o_dv[0] = dvalid_s; o_se[0] = serr_s; o_tk[0] = tick_s;
    o_dout[1] = dout_t;  o_dv[1] = dvalid_t; o_se[1] = serr_t; o_tk[1] = tick_t;
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (rel cyc %0d)", tag, obs, exp, cyc - t_ref);
    end
  endtask

  // Scoreboard side: every output pulse must match the head of its queue.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (o_dv[k]) begin
        total++;
        assert (qv[k].size() > 0) else begin
          bad++;
          $error("FAIL dvalid_extra[%0d]: observed dvalid at rel cyc %0d expected none", k, cyc - t_ref);
        end
        if (qv[k].size() > 0) begin
          m_e = qv[k].pop_front();
          chk($sformatf("dvalid_time[%0d]", k), cyc - t_ref, m_e.cyc);
          chk($sformatf("dout[%0d]", k), o_dout[k], m_e.d);
        end
      end
      if (o_se[k]) begin
        total++;
        assert (qe[k].size() > 0) else begin
          bad++;
          $error("FAIL stuff_err_extra[%0d]: observed stuff_err at rel cyc %0d expected none", k, cyc - t_ref);
        end
        if (qe[k].size() > 0) begin
          m_c = qe[k].pop_front();
          chk($sformatf("stuff_err_time[%0d]", k), cyc - t_ref, m_c);
        end
      end
      if (o_tk[k]) begin
        total++;
        assert (qt[k].size() > 0) else begin
          bad++;
          $error("FAIL tick_extra[%0d]: observed sample_tick at rel cyc %0d expected none", k, cyc - t_ref);
        end
        if (qt[k].size() > 0) begin
          m_c = qt[k].pop_front();
          chk($sformatf("tick_time[%0d]", k), cyc - t_ref, m_c);
        end
      end
    end
  end

  task automatic exp_v(input int rel, input logic d_single, input logic d_triple);
    ev_t e;
    e.cyc = rel; e.d = d_single; qv[0].push_back(e);
    e.d = d_triple;              qv[1].push_back(e);
  endtask

  task automatic exp_t(input int rel);
    qt[0].push_back(rel);
    qt[1].push_back(rel);
  endtask

  task automatic exp_e(input int rel);
    qe[0].push_back(rel);
    qe[1].push_back(rel);
  endtask

  task automatic wait_to(input int rel);
    while (cyc < t_ref + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int rel, input logic v);
    wait_to(rel);
    din = v;
  endtask

  // Pin falls in cycle 0 of the scenario (the SOF edge).
  task automatic start_frame();
    @(posedge clk);
    #1;
    t_ref = cyc;
    din = 1'b0;
  endtask

  task automatic end_scn(input string name, input int off_rel);
    wait_to(off_rel);
    en  = 1'b0;
    din = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_missing_dvalid[%0d]", name, k), qv[k].size(), 0);
      chk($sformatf("%s_missing_stuff_err[%0d]", name, k), qe[k].size(), 0);
      chk($sformatf("%s_missing_tick[%0d]", name, k), qt[k].size(), 0);
    end
    en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; din = 1'b1; destuff_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_dout[%0d]", k), o_dout[k], 1);
      chk($sformatf("rst_dvalid[%0d]", k), o_dv[k], 0);
      chk($sformatf("rst_stuff_err[%0d]", k), o_se[k], 0);
      chk($sformatf("rst_tick[%0d]", k), o_tk[k], 0);
    end
    rst_n = 1'b1;
    en = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Reset mid-bit after the SOF sample, then idle with din toggling and en=0.
    start_frame();
    exp_v(72, 1'b0, 1'b0); exp_t(72);
    wait_to(150);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst_dout[%0d]", k), o_dout[k], 1);
      chk($sformatf("midrst_dvalid[%0d]", k), o_dv[k], 0);
    end
    wait_to(160);
    en = 1'b0;
    din = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) drive(170 + i * 25, (i % 2) != 0);
    wait_to(450);
    for (int k = 0; k < 2; k++) chk($sformatf("idle_dout[%0d]", k), o_dout[k], 1);
    end_scn("reset", 450);

    // Ideal bits: SOF, 0, 1, 1, 0.
    start_frame();
    exp_v(72, 0, 0); exp_v(172, 0, 0); exp_v(272, 1, 1); exp_v(372, 1, 1); exp_v(472, 0, 0);
    for (int i = 0; i < 5; i++) exp_t(72 + i * 100);
    drive(200, 1'b1); drive(400, 1'b0);
    end_scn("ideal", 500);

    // SOF + four 0 + stuff 1 + 0.
    start_frame();
    for (int i = 0; i < 5; i++) exp_v(72 + i * 100, 0, 0);
    exp_v(672, 0, 0);
    for (int i = 0; i < 7; i++) exp_t(72 + i * 100);
    drive(500, 1'b1); drive(600, 1'b0);
    end_scn("stuff", 700);

    // SOF + five 0 -> stuff error at the sixth sample.
    start_frame();
    for (int i = 0; i < 5; i++) exp_v(72 + i * 100, 0, 0);
    exp_e(572);
    for (int i = 0; i < 6; i++) exp_t(72 + i * 100);
    end_scn("stuff_err", 600);

    // Same pattern with destuffing off: every sample is a data bit.
    destuff_en = 1'b0;
    start_frame();
    for (int i = 0; i < 6; i++) begin exp_v(72 + i * 100, 0, 0); exp_t(72 + i * 100); end
    end_scn("no_destuff", 600);
    destuff_en = 1'b1;

    // Resync: late edge lengthens SEG1 by 1 tq; early edge in SEG2 last tq restarts.
    start_frame();
    exp_v(72, 0, 0); exp_v(172, 1, 1); exp_v(282, 0, 0); exp_v(382, 1, 1); exp_v(477, 0, 0);
    exp_t(72); exp_t(172); exp_t(282); exp_t(382); exp_t(477);
    drive(100, 1'b1); drive(215, 1'b0); drive(310, 1'b1); drive(405, 1'b0);
    end_scn("resync", 520);

    // One-tq dominant glitch over the sample point of a recessive bit.
    start_frame();
    exp_v(72, 0, 0); exp_v(172, 0, 1);
    exp_t(72); exp_t(172);
    drive(100, 1'b1); drive(163, 1'b0); drive(173, 1'b1);
    end_scn("glitch", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_rx_bit_timing.md
Name: can_rx_bit_timing

Overview:
- Parametrised successor to the fixed mid-bit CAN RX sampler.
- Receives the raw CAN RX line, divides each bit into time quanta (tq), hard-syncs on SOF and resynchronises on later edges within SJW.
- Samples at a programmable sample point, in single or triple (majority) mode, and removes stuff bits.
- Feeds the frame decoder one valid bit per non-stuff bit, plus a stuff-error flag.

Parameters:
- BRP, 10: clk cycles per tq (>=1).
- TSEG1, 6: tq in prop+phase1 segment (>=3 when TRIPLE_SAMPLE=1, else >=1).
- TSEG2, 3: tq in phase2 segment (>=SJW, >=1).
- SJW, 1: resync jump width in tq (1..4).
- TRIPLE_SAMPLE, 0: 1 = majority of 3 samples, 0 = single sample.
- Bit time = BRP*(1+TSEG1+TSEG2) clk; defaults give 100 clk = 1 Mb/s at 100 MHz.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  reset: asynchronous, active-low
- en  in  1  receive enable; high from bus-idle through end of frame
- din  in  1  raw CAN RX line (1 = recessive)
- destuff_en  in  1  1 = apply destuffing (SOF through CRC field)
- dout  out  1  received (destuffed) bit value
- dvalid  out  1  one-clk pulse; dout valid this cycle
- stuff_err  out  1  one-clk pulse; 6th equal consecutive bit detected
- sample_tick  out  1  one-clk pulse at every sample point, including stuff bits (for bit monitor)

Behaviour:
- Reset: dout=1, dvalid=0, stuff_err=0, sample_tick=0, FSM=IDLE, all counters 0, sync flops=1, prev sampled bit=1.
- Input handling:
  - din passes through a 2-flop synchroniser giving ds.
  - edge = ds_prev=1 and ds=0 (recessive-to-dominant only).
- Prescaler:
  - Counts 0..BRP-1.
  - tq_end when count = BRP-1.
  - Reset to 0 on hard sync and on immediate-restart resync.
- FSM states: IDLE, SYNC_SEG (1 tq), SEG1 (TSEG1 + ext tq), SEG2 (TSEG2 - short tq).
  - IDLE -> SYNC_SEG: en=1 and edge (hard sync). The edge clock is the first clk of SYNC_SEG.
  - SYNC_SEG -> SEG1 -> SEG2 -> SYNC_SEG: on tq_end of the last tq of each segment.
  - Any state -> IDLE: en=0, next clk. No dvalid, stuff_err or sample_tick in that clk or later.
- Sample point: last clk of the last SEG1 tq.
  - Single mode: bit = ds.
  - Triple mode: bit = majority of ds captured at the last clk of each of the final 3 SEG1 tq.
  - All outputs are registered; dvalid/stuff_err/sample_tick assert the clk after the sample point.
  - With hard sync at t0, first dvalid is at t0+BRP*(1+TSEG1), i.e. 70 clk with defaults (72 clk after the din pin edge).
- Resync: at most one per bit, only when the previous sampled bit=1.
  - Edge in SYNC_SEG: no action.
  - Edge in SEG1 tq index k (1-based): ext = min(k, SJW); SEG1 is lengthened by ext tq.
  - Edge in SEG2 with r tq remaining (including current):
    - if r <= SJW: end SEG2 now; the edge clk begins a new SYNC_SEG and the prescaler resets;
    - else short = SJW.
  - ext and short clear at SYNC_SEG entry.
- Destuffing:
  - run counter 1..5 and last value, both cleared on IDLE entry.
  - The SOF sample starts the run at 1.
  - When destuff_en=1 and run=5, the next sample is a stuff bit:
    - if it equals last: stuff_err pulse, no dvalid;
    - else: no dvalid, run=1, last=new value.
  - Otherwise: dvalid pulse with dout=bit, run increments when equal else resets to 1.
  - When destuff_en=0: every sample gives dvalid, and the run counter holds 0.
- Simultaneous events:
  - en falling on a sample-point clk: sample discarded.
  - Edge on a sample-point clk: the sample uses pre-edge timing; resync evaluates as SEG1 last tq.
- rst_n low at any time: immediate return to reset values; no partial pulse.

Test Plan:
- Reset mid-bit, then idle: dout=1 and dvalid=0 throughout; no dvalid while en=0 even when din toggles.
- Defaults, en=1; din 1->0 at clk 0, then ideal bits 0,1,1,0 at 100 clk each, destuff_en=1 -> dvalid at clk 72,172,272,372,472 with dout 0,0,1,1,0.
- Stuffing: SOF + four 0 + 1 (stuff) + 0 -> 5 dvalid with dout=0; no dvalid at 6th sample but sample_tick=1; 7th sample gives dvalid, dout=0.
- Stuff error: SOF + five 0 -> stuff_err=1 for exactly 1 clk at the 6th sample point (clk 572); no dvalid.
- Resync: recessive bit, then next falling edge 15 clk late (SEG1 tq2) -> SEG1 lengthened by 1 tq; that bit's sample lands 10 clk later than nominal. Edge 5 clk early in SEG2 last tq -> immediate restart; next sample 70 clk after the edge.
- TRIPLE_SAMPLE=1: recessive bit with dominant glitch spanning 1 tq at the sample point -> dout=1. Same with TRIPLE_SAMPLE=0 -> dout=0.
